// File: rtl/app_hw_gpio_bridge.sv
// ---------------------------------------------------------------------------
// app_hw_gpio_bridge
//
// Parametrised OPB register-bus bridge between a generic hardware input
// vector and a generic hardware output vector.
//
// It provides:
//   - a multi-flop synchroniser on every hardware input;
//   - a loopback output mode (inputs mirrored onto outputs, wrapping modulo
//     NUM_IN) or a register-driven output mode;
//   - sticky per-bit edge flags (rise/fall enable, write-1-to-clear) that
//     feed a level interrupt;
//   - a saturating event counter on one selectable channel.
//
// Ports:
//   OPB_CLK   in   1        clock for all logic
//   OPB_RST   in   1        synchronous, active-high reset
//   OPB_DI    in   32       bus write data
//   OPB_DO    out  32       bus read data, registered, held between reads
//   OPB_ADDR  in   32       byte address, only [4:2] decoded
//   APP_RE    in   1        one-cycle read strobe
//   APP_WE    in   1        one-cycle write strobe (wins over APP_RE)
//   HW_IN     in   NUM_IN   asynchronous hardware inputs
//   HW_OUT    out  NUM_OUT  registered hardware outputs
//   APP_IRQ   out  1        level interrupt, IRQ_EN & |EDGE_STAT, registered
//
// Register map (word offsets):
//   0x00 CTRL      bit0 MODE, bit1 IRQ_EN, [12:8] CNT_SEL
//   0x04 OUT_REG   [NUM_OUT-1:0]
//   0x08 IN_RAW    synchronised inputs (RO)
//   0x0C EDGE_STAT sticky edge flags (W1C)
//   0x10 RISE_EN
//   0x14 FALL_EN
//   0x18 EVT_CNT   event counter (RO, any write clears)
//   0x1C VERSION   {8'h02, NUM_IN, NUM_OUT, SYNC_STAGES}
// ---------------------------------------------------------------------------
module app_hw_gpio_bridge #(
    parameter int NUM_IN      = 9,
    parameter int NUM_OUT     = 17,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic               OPB_CLK,
    input  logic               OPB_RST,
    input  logic [31:0]        OPB_DI,
    output logic [31:0]        OPB_DO,
    input  logic [31:0]        OPB_ADDR,
    input  logic               APP_RE,
    input  logic               APP_WE,
    input  logic [NUM_IN-1:0]  HW_IN,
    output logic [NUM_OUT-1:0] HW_OUT,
    output logic               APP_IRQ
);

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_OUT_REG = 3'd1;
    localparam logic [2:0] ADDR_IN_RAW  = 3'd2;
    localparam logic [2:0] ADDR_EDGE    = 3'd3;
    localparam logic [2:0] ADDR_RISE_EN = 3'd4;
    localparam logic [2:0] ADDR_FALL_EN = 3'd5;
    localparam logic [2:0] ADDR_EVT_CNT = 3'd6;
    localparam logic [2:0] ADDR_VERSION = 3'd7;

    localparam logic [31:0] VERSION_WORD =
        {8'h02, 8'(NUM_IN), 8'(NUM_OUT), 8'(SYNC_STAGES)};

    // Widened so CNT_SEL (0..31) can be compared against NUM_IN (up to 32).
    localparam logic [5:0] NUM_IN_W = 6'(NUM_IN);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][NUM_IN-1:0] sync_q, sync_d;
    logic [NUM_IN-1:0]    in_d_q, in_d_d;
    logic                 mode_q, mode_d;
    logic                 irq_en_q, irq_en_d;
    logic [4:0]           cnt_sel_q, cnt_sel_d;
    logic [NUM_OUT-1:0]   out_reg_q, out_reg_d;
    logic [NUM_IN-1:0]    edge_stat_q, edge_stat_d;
    logic [NUM_IN-1:0]    rise_en_q, rise_en_d;
    logic [NUM_IN-1:0]    fall_en_q, fall_en_d;
    logic [CNT_WIDTH-1:0] evt_cnt_q, evt_cnt_d;
    logic [NUM_OUT-1:0]   hw_out_q, hw_out_d;
    logic [31:0]          opb_do_q, opb_do_d;
    logic                 irq_q, irq_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [NUM_IN-1:0]  in_s;
    logic [NUM_OUT-1:0] loop_vec;
    logic [NUM_IN-1:0]  rise, fall, evt;
    logic [31:0]        evt_pad;
    logic               cnt_hit;
    logic [2:0]         reg_sel;
    logic               wr_en, rd_en;
    logic [31:0]        rdata;
    logic [NUM_IN-1:0]  w1c_mask;

    // Address bits outside [4:2] and write-data bits beyond the register
    // widths are intentionally ignored.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{OPB_ADDR[31:5], OPB_ADDR[1:0], OPB_DI};

    assign in_s = sync_q[SYNC_STAGES-1];

    // Loopback wiring: output k mirrors synchronised input (k mod NUM_IN).
    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_loop
            assign loop_vec[gi] = in_s[gi % NUM_IN];
        end
    endgenerate

    always_comb begin
        // Bus decode; a simultaneous write suppresses the read.
        reg_sel = OPB_ADDR[4:2];
        wr_en   = APP_WE;
        rd_en   = APP_RE & ~APP_WE;

        // Synchroniser shift and the extra delay flop used for edge detect.
        sync_d = {sync_q[SYNC_STAGES-2:0], HW_IN};
        in_d_d = in_s;

        rise = in_s & ~in_d_q;
        fall = ~in_s & in_d_q;
        evt  = (rise & rise_en_q) | (fall & fall_en_q);

        // Register defaults: hold.
        mode_d    = mode_q;
        irq_en_d  = irq_en_q;
        cnt_sel_d = cnt_sel_q;
        out_reg_d = out_reg_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;

        if (wr_en) begin
            case (reg_sel)
                ADDR_CTRL: begin
                    mode_d    = OPB_DI[0];
                    irq_en_d  = OPB_DI[1];
                    cnt_sel_d = OPB_DI[12:8];
                end
                ADDR_OUT_REG: out_reg_d = OPB_DI[NUM_OUT-1:0];
                ADDR_RISE_EN: rise_en_d = OPB_DI[NUM_IN-1:0];
                ADDR_FALL_EN: fall_en_d = OPB_DI[NUM_IN-1:0];
                default: ;
            endcase
        end

        // Sticky flags: a new edge in the same cycle as its clear keeps
        // the flag set, so no event is ever lost.
        w1c_mask    = (wr_en && reg_sel == ADDR_EDGE) ? OPB_DI[NUM_IN-1:0] : '0;
        edge_stat_d = (edge_stat_q & ~w1c_mask) | evt;

        // Event counter: zero-padded so an out-of-range CNT_SEL never hits.
        evt_pad = 32'(evt);
        cnt_hit = ({1'b0, cnt_sel_q} < NUM_IN_W) && evt_pad[cnt_sel_q];
        if (wr_en && reg_sel == ADDR_EVT_CNT) begin
            evt_cnt_d = '0;
        end else if (cnt_hit && evt_cnt_q != {CNT_WIDTH{1'b1}}) begin
            evt_cnt_d = evt_cnt_q + 1'b1;
        end else begin
            evt_cnt_d = evt_cnt_q;
        end

        hw_out_d = mode_q ? out_reg_q : loop_vec;
        irq_d    = irq_en_q & (|edge_stat_q);

        // Read mux; unused bits read as zero.
        case (reg_sel)
            ADDR_CTRL:    rdata = {19'b0, cnt_sel_q, 6'b0, irq_en_q, mode_q};
            ADDR_OUT_REG: rdata = 32'(out_reg_q);
            ADDR_IN_RAW:  rdata = 32'(in_s);
            ADDR_EDGE:    rdata = 32'(edge_stat_q);
            ADDR_RISE_EN: rdata = 32'(rise_en_q);
            ADDR_FALL_EN: rdata = 32'(fall_en_q);
            ADDR_EVT_CNT: rdata = 32'(evt_cnt_q);
            ADDR_VERSION: rdata = VERSION_WORD;
            default:      rdata = '0;
        endcase
        opb_do_d = rd_en ? rdata : opb_do_q;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge OPB_CLK) begin
        if (OPB_RST) begin
            sync_q      <= '0;
            in_d_q      <= '0;
            mode_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            cnt_sel_q   <= '0;
            out_reg_q   <= '0;
            edge_stat_q <= '0;
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            evt_cnt_q   <= '0;
            hw_out_q    <= '0;
            opb_do_q    <= '0;
            irq_q       <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            in_d_q      <= in_d_d;
            mode_q      <= mode_d;
            irq_en_q    <= irq_en_d;
            cnt_sel_q   <= cnt_sel_d;
            out_reg_q   <= out_reg_d;
            edge_stat_q <= edge_stat_d;
            rise_en_q   <= rise_en_d;
            fall_en_q   <= fall_en_d;
            evt_cnt_q   <= evt_cnt_d;
            hw_out_q    <= hw_out_d;
            opb_do_q    <= opb_do_d;
            irq_q       <= irq_d;
        end
    end

    assign OPB_DO  = opb_do_q;
    assign HW_OUT  = hw_out_q;
    assign APP_IRQ = irq_q;

endmodule

// File: tb/tb_app_hw_gpio_bridge.sv
// ---------------------------------------------------------------------------
// Testbench for app_hw_gpio_bridge (NUM_IN=9, NUM_OUT=17, SYNC_STAGES=2,
// CNT_WIDTH=2 so counter saturation is reachable in a few edges).
// Expected values are queued when stimulus is applied and popped when the
// DUT output is sampled, one millisecond-free step (#1) after each edge.
// ---------------------------------------------------------------------------
module tb_app_hw_gpio_bridge;

    localparam logic [31:0] A_CTRL    = 32'h00;
    localparam logic [31:0] A_OUT_REG = 32'h04;
    localparam logic [31:0] A_IN_RAW  = 32'h08;
    localparam logic [31:0] A_EDGE    = 32'h0C;
    localparam logic [31:0] A_RISE_EN = 32'h10;
    localparam logic [31:0] A_FALL_EN = 32'h14;
    localparam logic [31:0] A_EVT_CNT = 32'h18;
    localparam logic [31:0] A_VERSION = 32'h1C;
    localparam logic [31:0] VERSION   = 32'h0209_1102;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] di = '0;
    logic [31:0] opb_do;
    logic [31:0] addr = '0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [8:0]  hw_in = '0;
    logic [16:0] hw_out;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got;
    logic [31:0] exp;

    app_hw_gpio_bridge #(
        .NUM_IN(9), .NUM_OUT(17), .SYNC_STAGES(2), .CNT_WIDTH(2)
    ) dut (
        .OPB_CLK (clk),
        .OPB_RST (rst),
        .OPB_DI  (di),
        .OPB_DO  (opb_do),
        .OPB_ADDR(addr),
        .APP_RE  (re),
        .APP_WE  (we),
        .HW_IN   (hw_in),
        .HW_OUT  (hw_out),
        .APP_IRQ (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; di = d; we = 1'b1;
        tick();
        we = 1'b0;
        $display("wr addr=%02h data=%08h", a[7:0], d);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a; re = 1'b1;
        tick();
        re = 1'b0;
        d = opb_do;
        $display("rd addr=%02h data=%08h", a[7:0], d);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        tick();
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if (32'(hw_out) !== exp) begin
            errors++; $display("FAIL reset_hw_out got %h exp %h", hw_out, exp);
        end
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if (32'(irq) !== exp) begin
            errors++; $display("FAIL reset_irq got %h exp %h", irq, exp);
        end
        for (int r = 0; r < 8; r++) begin
            exp_q.push_back(r == 7 ? VERSION : 32'h0);
            bus_read(32'(r * 4), got);
            exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                errors++; $display("FAIL reset_reg%0d got %h exp %h", r, got, exp);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_loopback();
        logic [8:0]  ins [3];
        logic [16:0] outs[3];
        logic [16:0] prev;
        ins[0] = 9'h05A; outs[0] = 17'h0B45A;
        ins[1] = 9'h1FF; outs[1] = 17'h1FFFF;
        ins[2] = 9'h0A5; outs[2] = 17'h14AA5;
        prev = 17'h0;
        for (int i = 0; i < 3; i++) begin
            hw_in = ins[i];
            // Two edges in, the output must still show the old value.
            exp_q.push_back(32'(prev));
            wait_cycles(2);
            exp = exp_q.pop_front(); checks++;
            if (32'(hw_out) !== exp) begin
                errors++; $display("FAIL loop_early%0d got %h exp %h", i, hw_out, exp);
            end
            exp_q.push_back(32'(outs[i]));
            tick();
            exp = exp_q.pop_front(); checks++;
            if (32'(hw_out) !== exp) begin
                errors++; $display("FAIL loop_out%0d got %h exp %h", i, hw_out, exp);
            end
            exp_q.push_back(32'(ins[i]));
            bus_read(A_IN_RAW, got);
            exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                errors++; $display("FAIL in_raw%0d got %h exp %h", i, got, exp);
            end
            prev = outs[i];
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_mode();
        bus_write(A_OUT_REG, 32'h0001_2345);
        bus_write(A_CTRL, 32'h1);
        exp_q.push_back(32'h12345);
        tick();
        exp = exp_q.pop_front(); checks++;
        if (32'(hw_out) !== exp) begin
            errors++; $display("FAIL mode_reg got %h exp %h", hw_out, exp);
        end
        hw_in = 9'h05A;
        exp_q.push_back(32'h12345);
        wait_cycles(4);
        exp = exp_q.pop_front(); checks++;
        if (32'(hw_out) !== exp) begin
            errors++; $display("FAIL mode_hold got %h exp %h", hw_out, exp);
        end
        bus_write(A_CTRL, 32'h0);
        exp_q.push_back(32'h0B45A);
        tick();
        exp = exp_q.pop_front(); checks++;
        if (32'(hw_out) !== exp) begin
            errors++; $display("FAIL mode_back got %h exp %h", hw_out, exp);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_edge_irq();
        hw_in = 9'h0;
        wait_cycles(4);
        bus_write(A_RISE_EN, 32'h1);
        bus_write(A_CTRL, 32'h2);
        hw_in = 9'h001;
        wait_cycles(4);
        exp_q.push_back(32'h1);
        exp = exp_q.pop_front(); checks++;
        if (32'(irq) !== exp) begin
            errors++; $display("FAIL irq_set got %h exp %h", irq, exp);
        end
        exp_q.push_back(32'h1);
        bus_read(A_EDGE, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL edge_rise got %h exp %h", got, exp);
        end
        // Clear: flag drops on the write edge, IRQ one cycle later.
        bus_write(A_EDGE, 32'h1);
        exp_q.push_back(32'h1);
        exp = exp_q.pop_front(); checks++;
        if (32'(irq) !== exp) begin
            errors++; $display("FAIL irq_lag got %h exp %h", irq, exp);
        end
        exp_q.push_back(32'h0);
        tick();
        exp = exp_q.pop_front(); checks++;
        if (32'(irq) !== exp) begin
            errors++; $display("FAIL irq_clr got %h exp %h", irq, exp);
        end
        exp_q.push_back(32'h0);
        bus_read(A_EDGE, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL edge_clr got %h exp %h", got, exp);
        end
        // Falling edge without FALL_EN leaves no flag.
        hw_in = 9'h0;
        wait_cycles(4);
        exp_q.push_back(32'h0);
        bus_read(A_EDGE, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL edge_fall got %h exp %h", got, exp);
        end
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if (32'(irq) !== exp) begin
            errors++; $display("FAIL irq_fall got %h exp %h", irq, exp);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_w1c_collision();
        hw_in = 9'h001;
        wait_cycles(4);
        hw_in = 9'h0;
        wait_cycles(4);
        hw_in = 9'h001;
        wait_cycles(2);
        // This write lands on the same edge that records the new rise.
        bus_write(A_EDGE, 32'h1);
        for (int c = 0; c < 3; c++) begin
            exp_q.push_back(32'h1);
            exp = exp_q.pop_front(); checks++;
            if (32'(irq) !== exp) begin
                errors++; $display("FAIL coll_irq%0d got %h exp %h", c, irq, exp);
            end
            tick();
        end
        exp_q.push_back(32'h1);
        bus_read(A_EDGE, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL coll_stat got %h exp %h", got, exp);
        end
        bus_write(A_EDGE, 32'h1);
        hw_in = 9'h0;
        wait_cycles(4);
    endtask

    // ------------------------------------------------------------------
    task automatic test_counter();
        bus_write(A_EDGE, 32'h1FF);
        bus_write(A_CTRL, 32'h0000_0300);
        bus_write(A_RISE_EN, 32'h8);
        bus_write(A_EVT_CNT, 32'h0);
        for (int i = 1; i <= 5; i++) begin
            hw_in = 9'h008; wait_cycles(3);
            hw_in = 9'h000; wait_cycles(3);
            exp_q.push_back(i > 3 ? 32'd3 : 32'(i));
            bus_read(A_EVT_CNT, got);
            exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                errors++; $display("FAIL cnt_edge%0d got %h exp %h", i, got, exp);
            end
        end
        bus_write(A_EVT_CNT, 32'hFFFF_FFFF);
        exp_q.push_back(32'h0);
        bus_read(A_EVT_CNT, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL cnt_clear got %h exp %h", got, exp);
        end
        // One counted edge, then an edge coinciding with the clear.
        hw_in = 9'h008; wait_cycles(3);
        hw_in = 9'h000; wait_cycles(3);
        exp_q.push_back(32'h1);
        bus_read(A_EVT_CNT, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL cnt_one got %h exp %h", got, exp);
        end
        hw_in = 9'h008;
        wait_cycles(2);
        bus_write(A_EVT_CNT, 32'h0);
        hw_in = 9'h000;
        wait_cycles(3);
        exp_q.push_back(32'h0);
        bus_read(A_EVT_CNT, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL cnt_coll got %h exp %h", got, exp);
        end
        // Out-of-range channel: edges are flagged but never counted.
        bus_write(A_EDGE, 32'h1FF);
        bus_write(A_CTRL, 32'h0000_0C00);
        for (int i = 0; i < 2; i++) begin
            hw_in = 9'h008; wait_cycles(3);
            hw_in = 9'h000; wait_cycles(3);
        end
        exp_q.push_back(32'h0);
        bus_read(A_EVT_CNT, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL cnt_sel12 got %h exp %h", got, exp);
        end
        exp_q.push_back(32'h8);
        bus_read(A_EDGE, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL sel12_stat got %h exp %h", got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_rw_collision();
        exp_q.push_back(VERSION);
        bus_read(A_VERSION, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL version got %h exp %h", got, exp);
        end
        addr = A_OUT_REG; di = 32'h0000_ABCD; re = 1'b1; we = 1'b1;
        tick();
        re = 1'b0; we = 1'b0;
        $display("rw addr=%02h data=%08h", A_OUT_REG[7:0], di);
        exp_q.push_back(VERSION);
        exp = exp_q.pop_front(); checks++;
        if (opb_do !== exp) begin
            errors++; $display("FAIL rw_do_hold got %h exp %h", opb_do, exp);
        end
        exp_q.push_back(32'h0000_ABCD);
        bus_read(A_OUT_REG, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL rw_write got %h exp %h", got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        bus_write(A_CTRL, 32'h0000_0303);
        bus_write(A_FALL_EN, 32'h1FF);
        exp_q.push_back(VERSION);
        bus_read(A_VERSION, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL pre_do got %h exp %h", got, exp);
        end
        tick();
        exp_q.push_back(32'h1);
        exp = exp_q.pop_front(); checks++;
        if (32'(irq) !== exp) begin
            errors++; $display("FAIL pre_irq got %h exp %h", irq, exp);
        end
        exp_q.push_back(32'h0ABCD);
        exp = exp_q.pop_front(); checks++;
        if (32'(hw_out) !== exp) begin
            errors++; $display("FAIL pre_hw_out got %h exp %h", hw_out, exp);
        end
        rst = 1'b1;
        tick();
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if (32'(hw_out) !== exp) begin
            errors++; $display("FAIL rst_hw_out got %h exp %h", hw_out, exp);
        end
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if (32'(irq) !== exp) begin
            errors++; $display("FAIL rst_irq got %h exp %h", irq, exp);
        end
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if (opb_do !== exp) begin
            errors++; $display("FAIL rst_do got %h exp %h", opb_do, exp);
        end
        rst = 1'b0;
        for (int r = 0; r < 7; r++) begin
            exp_q.push_back(32'h0);
            bus_read(32'(r * 4), got);
            exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                errors++; $display("FAIL rst_reg%0d got %h exp %h", r, got, exp);
            end
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_loopback();
        test_mode();
        test_edge_irq();
        test_w1c_collision();
        test_counter();
        test_rw_collision();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/app_hw_gpio_bridge.md
Name: app_hw_gpio_bridge

Overview:
- Parametrised successor to the fixed-pin application-to-hardware pin bridge.
- Sits on the OPB register bus and connects a generic input vector HW_IN to a generic output vector HW_OUT.
- Adds input synchronisation, a selectable loopback or register-driven output mode, sticky edge detection with interrupt, and a saturating event counter.
- Replaces per-pin hand wiring for future APP FPGA pin groups.

Parameters:
- NUM_IN, 9, number of hardware inputs (1..32).
- NUM_OUT, 17, number of hardware outputs (1..32).
- SYNC_STAGES, 2, input synchroniser flops per bit (2..4).
- CNT_WIDTH, 16, event counter width (1..32).

Ports:
- OPB_CLK  in  1  single clock for all logic.
- OPB_RST  in  1  synchronous, active-high reset.
- OPB_DI  in  32  write data.
- OPB_DO  out  32  read data, registered.
- OPB_ADDR  in  32  byte address; OPB_ADDR[4:2] decoded, other bits ignored.
- APP_RE  in  1  read strobe, one cycle.
- APP_WE  in  1  write strobe, one cycle.
- HW_IN  in  NUM_IN  asynchronous hardware inputs.
- HW_OUT  out  NUM_OUT  registered hardware outputs.
- APP_IRQ  out  1  level interrupt.

Behaviour:
- Reset (synchronous, active-high): all registers, synchroniser flops, HW_OUT, OPB_DO and APP_IRQ are 0.
- Register map:
  - 0x00 CTRL (RW): bit0 MODE (0 = loopback, 1 = register), bit1 IRQ_EN, bits[12:8] CNT_SEL (channel index).
  - 0x04 OUT_REG (RW): [NUM_OUT-1:0].
  - 0x08 IN_RAW (RO): synchronised inputs.
  - 0x0C EDGE_STAT (W1C): sticky edge flags.
  - 0x10 RISE_EN (RW).
  - 0x14 FALL_EN (RW).
  - 0x18 EVT_CNT (RO; any write clears it).
  - 0x1C VERSION (RO): {8'h02, 8'(NUM_IN), 8'(NUM_OUT), 8'(SYNC_STAGES)}.
- Unused register bits read 0. Writes to RO addresses other than 0x18 are ignored.
- Synchroniser: in_s = HW_IN delayed by SYNC_STAGES flops. in_d = in_s delayed by one more flop.
- Output mode:
  - MODE=0: HW_OUT[k] <= in_s[k mod NUM_IN] every cycle. With defaults, bits 0-8 = in_s[8:0], bits 9-16 = in_s[7:0].
  - MODE=1: HW_OUT <= OUT_REG.
  - Latency from a HW_IN change to HW_OUT in loopback = SYNC_STAGES+1 cycles.
  - A mode change takes effect on HW_OUT one cycle after the CTRL write cycle.
- Edge detect:
  - rise[k] = in_s[k] & ~in_d[k]; fall[k] = ~in_s[k] & in_d[k].
  - EDGE_STAT[k] sets on (rise[k] & RISE_EN[k]) | (fall[k] & FALL_EN[k]).
  - A W1C write clears the bits written as 1. A set in the same cycle as a clear of that bit wins; the bit stays 1.
- IRQ: APP_IRQ registered, = IRQ_EN & |EDGE_STAT. It deasserts one cycle after the last flag is cleared.
- Event counter:
  - Increments on an enabled edge of channel CNT_SEL.
  - Saturates at all-ones with no wrap.
  - If CNT_SEL >= NUM_IN the counter never increments.
  - A write to 0x18 in the same cycle as an edge: the clear wins; the result is 0.
- Bus:
  - A read registers OPB_DO on the cycle APP_RE is high; data is valid the next cycle and held until the next read.
  - W1C reads return the current value with no side effect.
  - APP_RE and APP_WE both high in one cycle: the write executes and the read is ignored (OPB_DO holds its previous value).
- Reset mid-operation: all state returns to reset values on the next edge; there is no partial-write retention.

Test Plan:
- Release reset; read all addresses -> 0 except VERSION=0x0209_1102; HW_OUT=0; APP_IRQ=0.
- MODE=0; drive HW_IN=9'h05A -> after 3 cycles HW_OUT=17'h0B45A. HW_IN=9'h1FF -> HW_OUT=17'h1FFFF. HW_IN=9'h0A5 -> HW_OUT=17'h14AA5. IN_RAW reads back 0x5A / 0x1FF / 0xA5.
- Write OUT_REG=0x1_2345 then CTRL.MODE=1 -> HW_OUT=17'h12345 one cycle after the CTRL write; toggling HW_IN leaves HW_OUT unchanged. MODE=0 -> HW_OUT returns to the loopback value.
- RISE_EN=0x001, IRQ_EN=1; pulse HW_IN[0] 0->1 -> EDGE_STAT=0x1, APP_IRQ=1. The falling edge does not set a flag. Write 0x1 to 0x0C -> EDGE_STAT=0, APP_IRQ=0 next cycle.
- W1C clear aligned with a new rising edge on the same bit -> EDGE_STAT bit remains 1, APP_IRQ stays 1.
- CNT_WIDTH=2 build, CNT_SEL=3, RISE_EN=0x8; 5 rising edges on HW_IN[3] -> EVT_CNT=3 (saturated). Write 0x18 -> 0. CNT_SEL=12 -> edges do not count. Assert OPB_RST mid-sequence -> all registers 0 next cycle.
